mult: RTL and testbench

Sequential signed 32×32 multiplier for the multicycle datapath, using radix-2 Booth recoding to produce the 64-bit product in the HI/LO registers. It is the counterpart of the datapath's iterative divider and runs under the same control-unit level-hold scheme. The control unit raises `mult_control` for a MULT instruction and holds it until `mult_end` is seen. The product is written into `high`/`low` in a single cycle when the operation completes.

---
 rtl/mult_if.sv | 28 ++
 rtl/mult.sv | 101 ++++++++++
 tb/tb_mult.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mult_if.sv
// Operand/result bundle between the control unit and the Booth multiplier.
// The control unit drives the request and operands; the multiplier returns HI/LO.
interface mult_if;
    logic        mult_control;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] high;
    logic [31:0] low;
    logic        mult_end;

    modport master (
        output mult_control,
        output a,
        output b,
        input  high,
        input  low,
        input  mult_end
    );

    modport slave (
        input  mult_control,
        input  a,
        input  b,
        output high,
        output low,
        output mult_end
    );
endinterface

// File: rtl/mult.sv
// Sequential signed 32x32 radix-2 Booth multiplier.
// One recoding step per cycle; the 64-bit product lands in HI/LO on the last step.
module mult (
    input  logic  clk,
    input  logic  reset,
    mult_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    logic [32:0] m;
    logic [32:0] acc;
    logic [31:0] q;
    logic        q_m1;
    logic [5:0]  cnt;
    logic [31:0] high;
    logic [31:0] low;
    logic        mult_end;

    logic [32:0] sum;
    logic [32:0] acc_sh;
    logic [31:0] q_sh;
    logic        q_m1_sh;

    // 33-bit accumulator keeps M = -2^31 from overflowing the add/subtract
    always_comb begin
        sum = acc;
        unique case (1'b1)
            (!q[0] && q_m1): sum = acc + m;
            (q[0] && !q_m1): sum = acc + ~m + 33'd1;
            default:         sum = acc;
        endcase
        acc_sh  = {sum[32], sum[32:1]};
        q_sh    = {sum[0], q[31:1]};
        q_m1_sh = q[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            m        <= '0;
            acc      <= '0;
            q        <= '0;
            q_m1     <= 1'b0;
            cnt      <= '0;
            high     <= '0;
            low      <= '0;
            mult_end <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    mult_end <= 1'b0;
                    if (bus.mult_control) begin
                        m     <= {bus.a[31], bus.a};
                        q     <= bus.b;
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.mult_control) begin
                        state <= IDLE;
                    end else begin
                        acc  <= acc_sh;
                        q    <= q_sh;
                        q_m1 <= q_m1_sh;
                        cnt  <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            high     <= acc_sh[31:0];
                            low      <= q_sh;
                            mult_end <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!bus.mult_control) begin
                        mult_end <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    mult_end <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.high     = high;
    assign bus.low      = low;
    assign bus.mult_end = mult_end;

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for the Booth multiplier against a 64-bit arithmetic model.
// Directed corner cases, abort, mid-run reset, then randomized back-to-back runs.
module tb_mult;

    logic clk;
    logic reset;
    int   checks;
    int   fails;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    mult_if bus ();

    mult dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(logic [31:0] x, logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns just after a negedge with request low.
    task automatic run_op(logic [31:0] x, logic [31:0] y, bit scramble);
        logic [63:0] exp;
        exp = ref_prod(x, y);
        bus.a = x;
        bus.b = y;
        bus.mult_control = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 31; i++) begin
            @(posedge clk);
            if (scramble) begin
                #1;
                bus.a = $urandom;
                bus.b = $urandom;
            end
        end
        @(negedge clk);
        chk("busy_end", {63'd0, bus.mult_end}, 64'd0);
        chk("busy_hold", {bus.high, bus.low}, {hi_m, lo_m});
        @(posedge clk);
        @(negedge clk);
        chk("end_rise", {63'd0, bus.mult_end}, 64'd1);
        chk("product", {bus.high, bus.low}, exp);
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        @(posedge clk);
        @(negedge clk);
        chk("end_hold", {63'd0, bus.mult_end}, 64'd1);
        chk("prod_hold", {bus.high, bus.low}, {hi_m, lo_m});
        bus.mult_control = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("end_fall", {63'd0, bus.mult_end}, 64'd0);
        chk("prod_keep", {bus.high, bus.low}, {hi_m, lo_m});
    endtask

    initial begin
        bit saw_end;
        checks = 0;
        fails  = 0;
        hi_m   = '0;
        lo_m   = '0;
        reset  = 1'b0;
        bus.mult_control = 1'b0;
        bus.a = '0;
        bus.b = '0;
        #1;
        chk("reset_prod", {bus.high, bus.low}, 64'd0);
        chk("reset_end", {63'd0, bus.mult_end}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(32'd3, 32'd5, 1'b0);
        chk("basic_lo", {32'd0, lo_m}, 64'h0000_000F);
        run_op(-32'sd7, 32'd6, 1'b0);
        chk("mixed_a", {hi_m, lo_m}, 64'hFFFF_FFFF_FFFF_FFD6);
        run_op(32'd6, -32'sd7, 1'b0);
        chk("mixed_b", {hi_m, lo_m}, 64'hFFFF_FFFF_FFFF_FFD6);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("min_min", {hi_m, lo_m}, 64'h4000_0000_0000_0000);
        run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        chk("max_max", {hi_m, lo_m}, 64'h3FFF_FFFF_0000_0001);
        run_op(32'd0, 32'hDEAD_BEEF, 1'b0);

        // Abort: 9x9 dropped after step 10 must leave 2x3 result untouched
        run_op(32'd2, 32'd3, 1'b0);
        bus.a = 32'd9;
        bus.b = 32'd9;
        bus.mult_control = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.mult_control = 1'b0;
        saw_end = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.mult_end) saw_end = 1'b1;
        end
        chk("abort_end", {63'd0, saw_end}, 64'd0);
        chk("abort_prod", {bus.high, bus.low}, 64'd6);
        run_op(32'd9, 32'd9, 1'b0);
        chk("restart", {hi_m, lo_m}, 64'h51);

        // Asynchronous reset mid-run, then start on the first released edge
        bus.a = 32'h1234_5678;
        bus.b = 32'h9ABC_DEF0;
        bus.mult_control = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_prod", {bus.high, bus.low}, 64'd0);
        chk("async_end", {63'd0, bus.mult_end}, 64'd0);
        hi_m = '0;
        lo_m = '0;
        @(negedge clk);
        reset = 1'b1;
        run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b0);

        // Randomized back-to-back runs, some with operands scrambled mid-run
        for (int n = 0; n < 20; n++) begin
            run_op($urandom, $urandom, n[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
